// File: rtl/avalon_mem_arbiter.sv
// rtl/avalon_mem_arbiter.sv - two-master Avalon-MM round-robin arbiter for the shared RAM slave
// Optional stall watchdog: define ARB_TIMEOUT_EN.
module avalon_mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   m0_address,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW-1:0]   m0_writedata,
    input  logic [DW/8-1:0] m0_byteenable,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    input  logic [AW-1:0]   m1_address,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW-1:0]   m1_writedata,
    input  logic [DW/8-1:0] m1_byteenable,
    output logic            m1_waitrequest,
    output logic [DW-1:0]   m1_readdata,
    output logic [AW-1:0]   s_address,
    output logic            s_read,
    output logic            s_write,
    output logic [DW-1:0]   s_writedata,
    output logic [DW/8-1:0] s_byteenable,
    input  logic            s_waitrequest,
    input  logic [DW-1:0]   s_readdata,
    output logic            arb_error
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state, state_nxt;
    logic   last_gnt, last_gnt_nxt;
    logic   req0, req1;
    logic   timeout_hit;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;
    logic          err_q;

    assign timeout_hit = (state != IDLE) && (to_cnt == CW'(TIMEOUT_CYCLES));
    assign arb_error   = err_q;

    // Counter restarts with every grant; it only counts stalled cycles of the current transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE || state_nxt == IDLE)
                to_cnt <= '0;
            else if (s_waitrequest)
                to_cnt <= to_cnt + 1'b1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign arb_error      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_gnt_nxt   = last_gnt;
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = req0;
        m1_waitrequest = req1;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_gnt))
                    state_nxt = GNT0;
                else if (req1)
                    state_nxt = GNT1;
            end
            GNT0: begin
                s_address      = m0_address;
                s_read         = m0_read & ~timeout_hit;
                s_write        = m0_write & ~timeout_hit;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest & ~timeout_hit;
                // A dropped request abandons the grant without counting as a turn.
                if (!req0) begin
                    state_nxt = IDLE;
                end else if (!s_waitrequest || timeout_hit) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b0;
                end
            end
            GNT1: begin
                s_address      = m1_address;
                s_read         = m1_read & ~timeout_hit;
                s_write        = m1_write & ~timeout_hit;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest & ~timeout_hit;
                if (!req1) begin
                    state_nxt = IDLE;
                end else if (!s_waitrequest || timeout_hit) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m0_readdata = timeout_hit ? DW'(32'hDEADBEEF) : s_readdata;
    assign m1_readdata = timeout_hit ? DW'(32'hDEADBEEF) : s_readdata;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// tb/tb_avalon_mem_arbiter.sv - directed self-checking bench for avalon_mem_arbiter
module tb_avalon_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   m0_address, m1_address, s_address;
    logic            m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0]   m0_writedata, m1_writedata, s_writedata;
    logic [DW/8-1:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic            m0_waitrequest, m1_waitrequest;
    logic [DW-1:0]   m0_readdata, m1_readdata, s_readdata;
    logic            s_read, s_write, s_waitrequest, arb_error;
    logic [DW-1:0]   mem [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    avalon_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .arb_error(arb_error)
    );

    // RAM slave: word array preset to A000_000i, written on accepted writes
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (s_write && !s_waitrequest) begin
            mem[s_address[5:2]] <= s_writedata;
        end
    end
    assign s_readdata = s_read ? mem[s_address[5:2]] : 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0;
        tick; tick;
        check("rst_s_read", s_read, 0);
        check("rst_s_write", s_write, 0);
        check("rst_arb_error", arb_error, 0);
        check("rst_m0_wait", m0_waitrequest, 0);
        reset = 1'b1;
        tick;

        // single-master write then read back
        m0_write = 1; m0_address = 32'h4; m0_writedata = 32'h2402_0002; m0_byteenable = 4'hF;
        #1;
        check("wr_req_s_write", s_write, 0);
        check("wr_req_m0_wait", m0_waitrequest, 1);
        tick;
        check("wr_gnt_s_write", s_write, 1);
        check("wr_gnt_addr", s_address, 32'h4);
        check("wr_gnt_data", s_writedata, 32'h2402_0002);
        check("wr_gnt_be", s_byteenable, 4'hF);
        check("wr_gnt_m0_wait", m0_waitrequest, 0);
        tick;
        m0_write = 0;
        #1;
        check("wr_done_s_write", s_write, 0);
        m0_read = 1;
        #1;
        check("rd_req_m0_wait", m0_waitrequest, 1);
        tick;
        check("rd_gnt_s_read", s_read, 1);
        check("rd_gnt_m0_wait", m0_waitrequest, 0);
        check("rd_gnt_data", m0_readdata, 32'h2402_0002);
        tick;
        m0_read = 0;

        // tie after reset: m0 first, then m1
        reset = 0; tick; reset = 1;
        m0_read = 1; m0_address = 32'h8; m1_read = 1; m1_address = 32'hC;
        #1;
        check("tie_idle_m0_wait", m0_waitrequest, 1);
        check("tie_idle_m1_wait", m1_waitrequest, 1);
        tick;
        check("tie1_addr", s_address, 32'h8);
        check("tie1_m0_wait", m0_waitrequest, 0);
        check("tie1_m1_wait", m1_waitrequest, 1);
        check("tie1_m0_rdata", m0_readdata, 32'hA000_0002);
        tick;
        m0_read = 0;
        #1;
        check("tie_gap_m1_wait", m1_waitrequest, 1);
        check("tie_gap_s_read", s_read, 0);
        tick;
        check("tie2_addr", s_address, 32'hC);
        check("tie2_m1_wait", m1_waitrequest, 0);
        check("tie2_m1_rdata", m1_readdata, 32'hA000_0003);
        check("tie2_m0_wait", m0_waitrequest, 0);
        tick;
        m1_read = 0;
        // m0 alone takes a turn, so the next tie belongs to m1
        m0_read = 1; m0_address = 32'h0;
        tick;
        check("solo_m0_read", s_read, 1);
        tick;
        m1_read = 1;
        tick;
        check("tie3_addr", s_address, 32'hC);
        check("tie3_m1_wait", m1_waitrequest, 0);
        check("tie3_m0_wait", m0_waitrequest, 1);
        tick;
        m1_read = 0;
        tick;
        check("tie4_addr", s_address, 32'h0);
        check("tie4_m0_wait", m0_waitrequest, 0);
        tick;
        m0_read = 0;

        // slave stall during m1 grant, m0 waiting
        m1_write = 1; m1_address = 32'h10; m1_writedata = 32'h55AA_55AA; m1_byteenable = 4'hF;
        s_waitrequest = 1;
        tick;
        m0_read = 1; m0_address = 32'h10;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_m1_wait", m1_waitrequest, 1);
            check("stall_m0_wait", m0_waitrequest, 1);
            check("stall_addr", s_address, 32'h10);
            check("stall_s_write", s_write, 1);
            check("stall_arb_error", arb_error, 0);
            if (i < 2) tick;
        end
        s_waitrequest = 0;
        #1;
        check("stall_end_m1_wait", m1_waitrequest, 0);
        tick;
        m1_write = 0;
        #1;
        check("stall_gap_m0_wait", m0_waitrequest, 1);
        check("stall_gap_s_read", s_read, 0);
        tick;
        check("stall_m0_read", s_read, 1);
        check("stall_m0_rdata", m0_readdata, 32'h55AA_55AA);
        tick;
        m0_read = 0;

        // m1 abandons its write while granted
        m1_write = 1; m1_address = 32'h14; m1_writedata = 32'h1234_5678;
        s_waitrequest = 1;
        tick;
        m0_read = 1; m0_address = 32'h14;
        #1;
        check("abn_s_write", s_write, 1);
        check("abn_m1_wait", m1_waitrequest, 1);
        m1_write = 0;
        tick;
        check("abn_idle_s_write", s_write, 0);
        check("abn_idle_s_read", s_read, 0);
        check("abn_idle_m0_wait", m0_waitrequest, 1);
        s_waitrequest = 0;
        tick;
        check("abn_m0_read", s_read, 1);
        check("abn_m0_wait", m0_waitrequest, 0);
        check("abn_m0_rdata", m0_readdata, 32'hA000_0005);
        tick;
        m0_read = 0;

        // asynchronous reset in the middle of a stalled m0 write
        m0_write = 1; m0_address = 32'h18; s_waitrequest = 1;
        tick;
        check("mid_s_write", s_write, 1);
        reset = 0;
        #1;
        check("mid_rst_s_write", s_write, 0);
        check("mid_rst_s_read", s_read, 0);
        check("mid_rst_arb_error", arb_error, 0);
        m0_write = 0; s_waitrequest = 0;
        tick;
        reset = 1;
        tick;

`ifdef ARB_TIMEOUT_EN
        m0_read = 1; m0_address = 32'h4; m1_read = 1; m1_address = 32'h8;
        s_waitrequest = 1;
        tick;
        for (int i = 0; i < 8; i++) begin
            check("to_stall_m0_wait", m0_waitrequest, 1);
            check("to_stall_arb_error", arb_error, 0);
            tick;
        end
        check("to_hit_m0_wait", m0_waitrequest, 0);
        check("to_hit_rdata", m0_readdata, 32'hDEAD_BEEF);
        check("to_hit_s_read", s_read, 0);
        tick;
        m0_read = 0;
        #1;
        check("to_err_set", arb_error, 1);
        tick;
        check("to_m1_addr", s_address, 32'h8);
        check("to_m1_wait", m1_waitrequest, 1);
        s_waitrequest = 0;
        #1;
        check("to_m1_done", m1_waitrequest, 0);
        check("to_m1_rdata", m1_readdata, 32'hA000_0002);
        tick;
        m1_read = 0;
        tick;
        check("to_err_sticky", arb_error, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
